// File: rtl/sr_cmd_gen_if.sv
// Command-side bundle between the raw request source and sr_cmd_gen.
// master drives the raw requests; slave (the generator) drives the pulses and count.
interface sr_cmd_gen_if;
  logic       set_in;
  logic       clr_in;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] cmd_cnt;

  modport master (output set_in, clr_in, input s, r, conflict, cmd_cnt);
  modport slave  (input set_in, clr_in, output s, r, conflict, cmd_cnt);
endinterface

// File: rtl/sr_cmd_gen.sv
// Sync + debounce of raw set/clear requests into mutually exclusive one-cycle s/r pulses.
// Latency DB_CYCLES+2 edges from first sampling edge; no backpressure, every rise is issued or flagged.
module sr_cmd_gen #(
  parameter int DB_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  sr_cmd_gen_if.slave bus
);

  localparam logic [7:0] LP_LAST = 8'(DB_CYCLES - 1);

  // Channel index 0 is set, index 1 is clear.
  logic [1:0]      w_raw;
  logic [1:0]      w_rise;
  logic [1:0]      r_sync_a;
  logic [1:0]      r_sync_b;
  logic [1:0]      r_db;
  logic [1:0]      r_db_d;
  logic [1:0][7:0] r_cnt;
  logic            r_s;
  logic            r_r;
  logic            r_conflict;
  logic [7:0]      r_cmd_cnt;

  assign w_raw  = {bus.clr_in, bus.set_in};
  assign w_rise = r_db & ~r_db_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a   <= '0;
      r_sync_b   <= '0;
      r_db       <= '0;
      r_db_d     <= '0;
      r_cnt      <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_cmd_cnt  <= 8'd0;
    end else begin
      r_sync_a <= w_raw;
      r_sync_b <= r_sync_a;
      r_db_d   <= r_db;
      // Any cycle agreeing with the current level restarts the debounce count.
      for (int i = 0; i < 2; i++) begin
        if (r_sync_b[i] == r_db[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_db[i]  <= r_sync_b[i];
          r_cnt[i] <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
      r_s        <= w_rise[0] & ~w_rise[1];
      r_r        <= w_rise[1] & ~w_rise[0];
      r_conflict <= w_rise[0] & w_rise[1];
      if (w_rise[0] ^ w_rise[1]) begin
        r_cmd_cnt <= r_cmd_cnt + 8'd1;
      end
    end
  end

  assign bus.s        = r_s;
  assign bus.r        = r_r;
  assign bus.conflict = r_conflict;
  assign bus.cmd_cnt  = r_cmd_cnt;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed table and sequences plus random bouncing inputs against a window model.
module tb_sr_cmd_gen;
  localparam int DB = 4;

  logic clk;
  logic rst;
  sr_cmd_gen_if bus ();

  sr_cmd_gen #(.DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the debounced level follows syncB once the last DB syncB samples agree.
  logic [1:0] m_a, m_b, m_db, m_db_d;
  logic       m_s, m_r, m_c;
  logic [7:0] m_cnt;
  bit         m_valid = 0;
  bit         win[2][$];

  always @(posedge clk) begin
    logic [1:0] rise;
    logic [1:0] raw;
    int ones;
    raw = {bus.clr_in, bus.set_in};
    if (rst) begin
      m_a = 0; m_b = 0; m_db = 0; m_db_d = 0;
      m_s = 0; m_r = 0; m_c = 0; m_cnt = 0;
      win[0].delete();
      win[1].delete();
    end else begin
      rise   = m_db & ~m_db_d;
      m_s    = rise[0] & ~rise[1];
      m_r    = rise[1] & ~rise[0];
      m_c    = rise[0] & rise[1];
      if (rise[0] != rise[1]) m_cnt = m_cnt + 8'd1;
      m_db_d = m_db;
      for (int ch = 0; ch < 2; ch++) begin
        win[ch].push_back(m_b[ch]);
        if (win[ch].size() > DB) void'(win[ch].pop_front());
        if (win[ch].size() == DB) begin
          ones = 0;
          foreach (win[ch][k]) ones += int'(win[ch][k]);
          if (ones == 0) m_db[ch] = 1'b0;
          else if (ones == DB) m_db[ch] = 1'b1;
        end
      end
      m_b = m_a;
      m_a = raw;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_s", int'(bus.s), int'(m_s));
      chk("model_r", int'(bus.r), int'(m_r));
      chk("model_conflict", int'(bus.conflict), int'(m_c));
      chk("model_cmd_cnt", int'(bus.cmd_cnt), int'(m_cnt));
    end
  end

  typedef struct {
    logic st;
    logic cl;
    int   ns;
    int   nr;
    int   nc;
    int   first;
    int   dcnt;
  } vec_t;

  vec_t tbl[4];
  int   exp_cnt;

  // Drive levels for n cycles from a negedge; count pulses and the edge index of the first one.
  task automatic run_level(input logic st, input logic cl, input int n,
                           output int ns, output int nr, output int nc, output int first);
    bus.set_in = st;
    bus.clr_in = cl;
    ns = 0; nr = 0; nc = 0; first = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((bus.s || bus.r || bus.conflict) && first < 0) first = k;
      ns += int'(bus.s);
      nr += int'(bus.r);
      nc += int'(bus.conflict);
      if (bus.s && bus.r) chk("s_and_r", 1, 0);
    end
  endtask

  initial begin
    int ns, nr, nc, first;
    int hold_s, hold_c;
    logic [2:0] pat;

    tbl[0] = '{st: 1, cl: 0, ns: 1, nr: 0, nc: 0, first: 6,  dcnt: 1};
    tbl[1] = '{st: 0, cl: 1, ns: 0, nr: 1, nc: 0, first: 6,  dcnt: 1};
    tbl[2] = '{st: 1, cl: 1, ns: 0, nr: 0, nc: 1, first: 6,  dcnt: 0};
    tbl[3] = '{st: 0, cl: 0, ns: 0, nr: 0, nc: 0, first: -1, dcnt: 0};

    // Reset with both requests held high.
    rst = 1'b1;
    bus.set_in = 1'b1;
    bus.clr_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_s", int'(bus.s), 0);
      chk("rst_r", int'(bus.r), 0);
      chk("rst_conflict", int'(bus.conflict), 0);
      chk("rst_cmd_cnt", int'(bus.cmd_cnt), 0);
    end
    rst = 1'b0;
    run_level(1, 1, 12, ns, nr, nc, first);
    chk("rst_rel_conflicts", nc, 1);
    chk("rst_rel_first", first, 6);
    chk("rst_rel_sr", ns + nr, 0);
    chk("rst_rel_cnt", int'(bus.cmd_cnt), 0);
    run_level(0, 0, 15, ns, nr, nc, first);
    exp_cnt = 0;

    foreach (tbl[i]) begin
      run_level(tbl[i].st, tbl[i].cl, 20, ns, nr, nc, first);
      exp_cnt += tbl[i].dcnt;
      chk($sformatf("tbl%0d_s", i), ns, tbl[i].ns);
      chk($sformatf("tbl%0d_r", i), nr, tbl[i].nr);
      chk($sformatf("tbl%0d_conflict", i), nc, tbl[i].nc);
      chk($sformatf("tbl%0d_first", i), first, tbl[i].first);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.cmd_cnt), exp_cnt);
      run_level(0, 0, 20, ns, nr, nc, first);
      chk($sformatf("tbl%0d_release", i), ns + nr + nc, 0);
    end

    // Bounce: 3-cycle highs must be rejected, then a steady press gives one r.
    for (int k = 0; k < 8; k++) begin
      run_level(1'b0, (k % 4) != 3, 1, ns, nr, nc, first);
      chk("bounce_quiet", ns + nr + nc, 0);
    end
    run_level(0, 1, 20, ns, nr, nc, first);
    exp_cnt++;
    chk("bounce_r", nr, 1);
    chk("bounce_first", first, DB + 2);
    run_level(0, 0, 15, ns, nr, nc, first);

    // Sequential set then clear.
    run_level(1, 0, 15, ns, nr, nc, first);
    chk("seq_s", ns, 1);
    chk("seq_s_only", nr + nc, 0);
    run_level(0, 0, 15, ns, nr, nc, first);
    run_level(0, 1, 15, ns, nr, nc, first);
    chk("seq_r", nr, 1);
    chk("seq_r_only", ns + nc, 0);
    run_level(0, 0, 15, ns, nr, nc, first);
    exp_cnt += 2;
    chk("seq_cnt", int'(bus.cmd_cnt), exp_cnt);

    // Wrap: start from reset, 257 presses.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 1; p <= 257; p++) begin
      run_level(1, 0, 8, ns, nr, nc, first);
      if (p == 255) chk("wrap_255", int'(bus.cmd_cnt), 255);
      if (p == 256) chk("wrap_256", int'(bus.cmd_cnt), 0);
      if (p == 257) chk("wrap_257", int'(bus.cmd_cnt), 1);
      run_level(0, 0, 8, ns, nr, nc, first);
    end

    // Reset three edges into a press; the held input restarts with full latency.
    bus.set_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_s", int'(bus.s), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_level(1, 0, 12, ns, nr, nc, first);
    chk("midrst_s", ns, 1);
    chk("midrst_first", first, 6);
    run_level(0, 0, 12, ns, nr, nc, first);

    // Random bouncing inputs, occasional reset; the model checks every cycle.
    hold_s = 0;
    hold_c = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold_s == 0) begin
        bus.set_in = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 9);
      end
      if (hold_c == 0) begin
        bus.clr_in = 1'($urandom_range(0, 1));
        hold_c = $urandom_range(1, 9);
      end
      pat = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0) && (pat != 0);
      hold_s--;
      hold_c--;
      @(posedge clk);
      @(negedge clk);
      if (bus.s && bus.r) chk("rand_s_and_r", 1, 0);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the SR flip-flop. It takes two raw, asynchronous, possibly bouncy level inputs (set request and clear request) and synchronises and debounces them. It then emits clean single-cycle `s`/`r` pulses that drive the flip-flop's `s` and `r` inputs directly. It guarantees that `s` and `r` are never asserted together, so the flip-flop never enters its undefined S=R=1 case. It also keeps a wrapping count of commands issued.

## Interface

Parameters:
- `DB_CYCLES`, default 4: number of consecutive cycles a synchronised input must differ from its debounced level before that level updates. Legal range is 1..255.

Ports:
- `clk`, input, 1: single clock. Every register in the block is clocked on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high. It is sampled on the rising edge of `clk`.
- `set_in`, input, 1: raw set request, asynchronous and may bounce.
- `clr_in`, input, 1: raw clear request, asynchronous and may bounce.
- `s`, output, 1: registered one-cycle set pulse to the SR flip-flop.
- `r`, output, 1: registered one-cycle reset pulse to the SR flip-flop.
- `conflict`, output, 1: registered one-cycle pulse that flags simultaneous set and clear rises.
- `cmd_cnt`, output, 8: count of `s` and `r` pulses issued. Wraps from 255 to 0.

## Operation

- Each channel (set, clear) has the same pipeline:
  - Two-flop synchroniser: `syncA`, then `syncB`.
  - 8-bit debounce counter `cnt`.
  - Debounced level `db` and its one-cycle delayed copy `db_d`.
- Debounce rule, evaluated each edge:
  - If `syncB == db`: `cnt` is set to 0.
  - Else if `cnt == DB_CYCLES-1`: `db` is set to `syncB` and `cnt` is set to 0.
  - Else: `cnt` increments by 1.
  - Any pulse shorter than `DB_CYCLES` cycles at `syncB` is discarded.
- Rise detect for a channel is `db & ~db_d`. A falling edge of `db` produces no output.
- Output register update each edge, where `set_rise` and `clr_rise` are the two channel rise detects:
  - `s` is set to `set_rise & ~clr_rise`.
  - `r` is set to `clr_rise & ~set_rise`.
  - `conflict` is set to `set_rise & clr_rise`.
  - `cmd_cnt` is set to `cmd_cnt + 1` (mod 256) when exactly one of `set_rise` and `clr_rise` is high. Otherwise it is unchanged.
- Holding an input high produces exactly one pulse. A new pulse requires a debounced release followed by a new debounced press.
- Rises on the two channels in different cycles are each honoured in order. Nothing is queued and nothing is dropped.
- Invariant: `s & r` is never 1.

## Timing

- Reset values, when `rst` is high at an edge:
  - `s`, `r`, `conflict` are 0.
  - `cmd_cnt` is 0.
  - All `syncA`, `syncB`, `db`, `db_d` and `cnt` registers are 0.
  - Reset takes priority over all other updates.
- Latency: let raw input rise be first sampled at edge E0 and held stable.
  - `syncB` is 1 after E1.
  - `db` is 1 after E(1+DB_CYCLES).
  - `s` (or `r`) is 1 for exactly one cycle after E(2+DB_CYCLES).
  - With default `DB_CYCLES=4`, the pulse is visible after the 6th edge following E0.
- Release latency is the same, up to `db` falling. No output is generated on release.
- Reset mid-operation: all in-flight debounce progress and pending pulses are lost.
  - An input still held high after `rst` deasserts counts as a fresh rise, because `db` restarts at 0.
  - That rise produces one pulse with full latency, measured from the first post-reset edge.
- Bounce during counting: any edge with `syncB == db` restarts the count from 0.
- `cmd_cnt` wraps from 255 to 0 with no flag.
- `conflict` cycles never increment `cmd_cnt`.

## Test plan

1. **Reset.** Hold `rst` 3 cycles with both inputs at 1, then release.
   - During reset, all outputs are 0 and `cmd_cnt=0`.
   - After release, one `s`/`r` conflict resolution occurs 6 edges later: `conflict=1` for 1 cycle, `s=r=0`, `cmd_cnt=0`.
2. **Clean set.** `DB_CYCLES=4`. Raise `set_in` and hold it for 20 cycles.
   - `s=1` for exactly one cycle, 6 edges after the first sampling edge.
   - `r=0` throughout. `cmd_cnt` goes from 0 to 1.
3. **Bounce reject.** Toggle `clr_in` as 1,1,1,0,1,1,1,0 (3-cycle highs), then hold it high.
   - No pulse during toggling.
   - A single `r` pulse `DB_CYCLES+2` edges after the final steady rise.
4. **Sequential commands.** Set press, release, clear press, release, with 15 cycles between each.
   - Exactly one `s` pulse, then one `r` pulse, never overlapping.
   - `cmd_cnt=2`.
5. **Wrap.** Issue 257 debounced set presses.
   - `cmd_cnt` reads 255 after the 255th, 0 after the 256th, and 1 after the 257th.
6. **Reset mid-count.** Raise `set_in` and assert `rst` 3 edges later for 1 cycle, keeping `set_in` high.
   - No `s` before reset.
   - One `s` pulse 6 edges after the first post-reset edge.
